// File: rtl/aha_clock_en_generator.sv
// Programmable clock-enable generator: one-cycle CE every DIV_CUR+1 clocks.
// Divisor changes use a 4-phase REQ/ACK handshake and take effect only at a period boundary.
module aha_clock_en_generator #(
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             DIV_REQ,
  input  logic [DIV_W-1:0] DIV_SEL,
  output logic             DIV_ACK,
  output logic             CE,
  output logic [DIV_W-1:0] DIV_CUR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_nxt_q, div_nxt_d;
  logic             ce_q, ce_d;
  logic             ack_q, ack_d;
  logic             at_end;
  logic             bnd;

  assign at_end = (cnt_q == div_cur_q);
  // A disabled generator is always at a boundary, so changes apply without waiting.
  assign bnd    = at_end || !EN;

  always_comb begin
    state_d   = state_q;
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    ack_d     = ack_q;
    ce_d      = EN && at_end;

    if (!EN || at_end) cnt_d = '0;
    else               cnt_d = cnt_q + DIV_W'(1);

    unique case (state_q)
      IDLE: begin
        if (DIV_REQ) begin
          div_nxt_d = DIV_SEL;
          state_d   = PEND;
        end
      end
      PEND: begin
        // Completes even if REQ has already dropped; ACK then lasts one cycle.
        if (bnd) begin
          div_cur_d = div_nxt_q;
          cnt_d     = '0;
          ack_d     = 1'b1;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (!DIV_REQ) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_cur_q <= DIV_W'(DEFAULT_DIV);
      div_nxt_q <= '0;
      ce_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      div_nxt_q <= div_nxt_d;
      ce_q      <= ce_d;
      ack_q     <= ack_d;
    end
  end

  assign CE      = ce_q;
  assign DIV_ACK = ack_q;
  assign DIV_CUR = div_cur_q;

endmodule
